// File: rtl/frame_sync.sv
// Frame parser: hunts 0x55,0xAA, buffers a length-prefixed payload, checks an additive checksum, then drains it.
// Optional inter-byte timeout enabled by defining FRAME_TIMEOUT_EN.
module frame_sync #(
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic [7:0] out_byte,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        HUNT0,
        HUNT1,
        LEN,
        PAYLOAD,
        CSUM,
        DRAIN
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] out_byte_q, out_byte_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       frame_ok_q, frame_ok_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] err_code_q, err_code_d;

    logic [7:0] buf_q [MAX_LEN];
    logic       buf_we;
    logic [7:0] nxt_idx;
    logic       timeout_hit;

    assign nxt_idx = idx_q + 8'd1;

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);

    logic [GAP_W-1:0] gap_q, gap_d;
    logic             timed_state;

    assign timed_state = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);

    // Counts cycles since the last accepted byte, so the strobe cycle itself is cycle 0.
    always_comb begin
        gap_d = '0;
        if (in_valid) begin
            gap_d = GAP_W'(1);
        end else if (timed_state) begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    assign timeout_hit = timed_state && !in_valid && (gap_q == GAP_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = 2'b00;
        buf_we      = 1'b0;

        case (state_q)
            HUNT0: begin
                if (in_valid && (in_byte == 8'h55)) begin
                    state_d = HUNT1;
                end
            end
            HUNT1: begin
                if (in_valid) begin
                    if (in_byte == 8'hAA) begin
                        state_d = LEN;
                    end else if (in_byte != 8'h55) begin
                        state_d = HUNT0;
                    end
                end
            end
            LEN: begin
                if (in_valid) begin
                    len_d = in_byte;
                    sum_d = in_byte;
                    idx_d = 8'd0;
                    if (in_byte > 8'(MAX_LEN)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b10;
                        state_d     = HUNT0;
                    end else if (in_byte == 8'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + in_byte;
                    idx_d  = nxt_idx;
                    if (idx_q == (len_q - 8'd1)) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (in_valid) begin
                    if (in_byte == sum_q) begin
                        frame_ok_d = 1'b1;
                        if (len_q == 8'd0) begin
                            state_d = HUNT0;
                        end else begin
                            // First byte goes out together with the frame_ok pulse.
                            state_d     = DRAIN;
                            idx_d       = 8'd0;
                            out_valid_d = 1'b1;
                            out_byte_d  = buf_q[0];
                            out_last_d  = (len_q == 8'd1);
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b01;
                        state_d     = HUNT0;
                    end
                end
            end
            DRAIN: begin
                if (in_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = 2'b00;
                end
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = HUNT0;
                    end else begin
                        idx_d      = nxt_idx;
                        out_byte_d = buf_q[nxt_idx[IDX_W-1:0]];
                        out_last_d = (nxt_idx == (len_q - 8'd1));
                    end
                end
            end
            default: begin
                state_d = HUNT0;
            end
        endcase

        if (timeout_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b11;
            state_d     = HUNT0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT0;
            len_q       <= 8'd0;
            sum_q       <= 8'd0;
            idx_q       <= 8'd0;
            out_byte_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload storage needs no reset; only indices below len_q are ever read.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[idx_q[IDX_W-1:0]] <= in_byte;
        end
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_frame_sync.sv
// Directed bench for frame_sync: good/bad frames, resync, oversize, backpressure, reset, timeout.
module tb_frame_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_byte;
    logic       in_valid;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    frame_sync #(.MAX_LEN(32), .TIMEOUT_CYC(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int ok_cnt    = 0;
    int err_cnt   = 0;
    int valid_cyc = 0;
    int stab_err  = 0;
    logic [7:0] rx_q [$];
    logic       rx_last_q [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'd0;
    logic       prev_last  = 1'b0;

    // Observe pulses and handshakes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_ok)  ok_cnt++;
            if (frame_err) err_cnt++;
            if (out_valid) valid_cyc++;
            if (prev_stall && !(out_valid && out_byte == prev_byte && out_last == prev_last))
                stab_err++;
            if (out_valid && out_ready) begin
                rx_q.push_back(out_byte);
                rx_last_q.push_back(out_last);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_byte;
        prev_last  = out_last;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [23:0] rx3();
        if (rx_q.size() != 3) return 24'hFFFFFF;
        return {rx_q[0], rx_q[1], rx_q[2]};
    endfunction

    function automatic logic [2:0] rxlast3();
        if (rx_last_q.size() != 3) return 3'b111;
        return {rx_last_q[0], rx_last_q[1], rx_last_q[2]};
    endfunction

    task automatic clear_rx();
        rx_q.delete();
        rx_last_q.delete();
    endtask

    // 55 AA 03 11 22 33 69 with out_ready high: exact-cycle drain of 11,22,33.
    task automatic good_frame(input string tag);
        int ok0;
        int err0;
        ok0  = ok_cnt;
        err0 = err_cnt;
        out_ready = 1'b1;
        clear_rx();
        send(8'h55); send(8'hAA); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
        send(8'h69);
        check({tag, "_ok_pulse"},   32'(frame_ok),  32'h1);
        check({tag, "_first_vld"},  32'(out_valid), 32'h1);
        check({tag, "_first_byte"}, 32'(out_byte),  32'h11);
        tick();
        tick();
        check({tag, "_last_byte"},  32'(out_byte),  32'h33);
        check({tag, "_last_flag"},  32'(out_last),  32'h1);
        tick();
        check({tag, "_vld_drop"},   32'(out_valid), 32'h0);
        tick();
        check({tag, "_stream"},     32'(rx3()),     32'h112233);
        check({tag, "_lasts"},      32'(rxlast3()), 32'h1);
        check({tag, "_ok_count"},   32'(ok_cnt - ok0),   32'h1);
        check({tag, "_err_count"},  32'(err_cnt - err0), 32'h0);
    endtask

    initial begin
        int ok0;
        int err0;
        int v0;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_last",  32'(out_last),  32'h0);
        check("rst_out_byte",  32'(out_byte),  32'h0);
        check("rst_frame_ok",  32'(frame_ok),  32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_err_code",  32'(err_code),  32'h0);
        reset = 1'b0;
        tick();

        good_frame("good1");

        // Bad checksum, then recovery
        ok0 = ok_cnt; err0 = err_cnt; v0 = valid_cyc;
        send(8'h55); send(8'hAA); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
        send(8'h68);
        check("csum_err_pulse", 32'(frame_err), 32'h1);
        check("csum_err_code",  32'(err_code),  32'h1);
        tick();
        check("csum_err_single", 32'(frame_err), 32'h0);
        repeat (4) tick();
        check("csum_no_valid", 32'(valid_cyc - v0), 32'h0);
        check("csum_no_ok",    32'(ok_cnt - ok0),   32'h0);
        check("csum_err_cnt",  32'(err_cnt - err0), 32'h1);
        good_frame("good2");

        // Resync on repeated 0x55, oversize length, then zero-length frame
        ok0 = ok_cnt; err0 = err_cnt; v0 = valid_cyc;
        send(8'h55); send(8'h55); send(8'hAA); send(8'h40);
        check("oversize_pulse", 32'(frame_err), 32'h1);
        check("oversize_code",  32'(err_code),  32'h2);
        tick();
        send(8'h55); send(8'hAA); send(8'h00); send(8'h00);
        check("zero_len_ok",    32'(frame_ok),  32'h1);
        check("zero_len_noval", 32'(out_valid), 32'h0);
        repeat (3) tick();
        check("zero_len_vcyc",  32'(valid_cyc - v0), 32'h0);
        check("zero_len_okcnt", 32'(ok_cnt - ok0),   32'h1);
        check("zero_len_errs",  32'(err_cnt - err0), 32'h1);

        // Backpressure with a stray byte during drain
        ok0 = ok_cnt; err0 = err_cnt;
        clear_rx();
        out_ready = 1'b0;
        send(8'h55); send(8'hAA); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
        send(8'h69);
        check("bp_ok_pulse",   32'(frame_ok),  32'h1);
        check("bp_first_byte", 32'(out_byte),  32'h11);
        for (int i = 0; i < 40 && out_valid; i++) begin
            out_ready = (i % 2) == 1;
            if (i == 1) begin
                in_byte  = 8'h77;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            if (i == 1) begin
                check("drop_err_pulse", 32'(frame_err), 32'h1);
                check("drop_err_code",  32'(err_code),  32'h0);
                check("drop_still_vld", 32'(out_valid), 32'h1);
            end
        end
        check("bp_drain_done", 32'(out_valid), 32'h0);
        out_ready = 1'b1;
        tick();
        check("bp_stream",    32'(rx3()),          32'h112233);
        check("bp_lasts",     32'(rxlast3()),      32'h1);
        check("bp_stable",    32'(stab_err),       32'h0);
        check("bp_ok_count",  32'(ok_cnt - ok0),   32'h1);
        check("bp_err_count", 32'(err_cnt - err0), 32'h1);

        // Reset mid-payload
        err0 = err_cnt;
        send(8'h55); send(8'hAA); send(8'h03); send(8'h11);
        reset = 1'b1;
        tick();
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_err",   32'(frame_err), 32'h0);
        check("midrst_ok",    32'(frame_ok),  32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_no_err", 32'(err_cnt - err0), 32'h0);
        good_frame("good5");

        // Inter-byte timeout
        err0 = err_cnt;
        send(8'h55); send(8'hAA); send(8'h03); send(8'h11);
`ifdef FRAME_TIMEOUT_EN
        repeat (62) tick();
        check("to_not_early", 32'(err_cnt - err0), 32'h0);
        tick();
        check("to_pulse", 32'(frame_err), 32'h1);
        check("to_code",  32'(err_code),  32'h3);
        tick();
`else
        repeat (1000) tick();
        check("no_to_pulse", 32'(err_cnt - err0), 32'h0);
        check("no_to_err",   32'(frame_err),      32'h0);
`endif
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        good_frame("good6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sync.md
# frame_sync

Byte-stream frame parser between the UART receiver and the distance processing stage. It consumes received bytes as single-cycle strobes and locks onto the 0x55,0xAA header, i.e. 16'hAA55 sent LSB-first. It then collects a length-prefixed payload into an internal buffer and checks an 8-bit additive checksum. Only verified payloads are released downstream, over a valid/ready byte stream with a last marker.

## Interface
- `MAX_LEN`, default 32: maximum payload bytes; the buffer is MAX_LEN×8.
- `TIMEOUT_CYC`, default 64: inter-byte gap limit in clk cycles. Used only with FRAME_TIMEOUT_EN.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_byte`  in  8  received byte; sampled only when `in_valid`=1.
- `in_valid`  in  1  single-cycle strobe, one per received byte.
- `out_byte`  out  8  payload byte to downstream.
- `out_valid`  out  1  `out_byte` is valid; held until accepted.
- `out_last`  out  1  qualifies the final payload byte of a frame.
- `out_ready`  in  1  downstream accept; a transfer occurs when `out_valid`&`out_ready`.
- `frame_ok`  out  1  1-cycle pulse: frame verified.
- `frame_err`  out  1  1-cycle pulse: frame rejected or byte dropped.
- `err_code`  out  2  cause, valid with `frame_err`:
  - 01: checksum
  - 10: length > MAX_LEN
  - 11: timeout
  - 00: byte dropped during DRAIN

## Operation
- Reset: all outputs 0, state HUNT0, and the sum, index and length registers cleared. Reset has priority over every other event, including mid-frame and mid-drain; the partial frame is discarded with no err pulse.
- States:
  - HUNT0: byte 0x55 → HUNT1; any other byte stays in HUNT0.
  - HUNT1: 0xAA → LEN; 0x55 stays in HUNT1 (resync); any other byte → HUNT0.
  - LEN: latch N=in_byte and sum=N.
    - N>MAX_LEN: err 10 → HUNT0.
    - N=0: → CSUM.
    - Otherwise: → PAYLOAD.
  - PAYLOAD: write buf[idx]=byte, sum+=byte (mod 256), idx++. After the Nth byte → CSUM.
  - CSUM: byte==sum gives a match; byte!=sum gives err 01 → HUNT0.
    - Match with N=0: frame_ok pulse → HUNT0.
    - Match with N>0: → DRAIN.
  - DRAIN: present buf[0..N-1] in order. out_last=1 on index N-1. After the last transfer → HUNT0.
- Bytes arriving in DRAIN are not stored: each gives a frame_err pulse with err_code 00, and the drain continues. Header hunting resumes only after DRAIN exits.
- Simultaneous error causes cannot occur, because each state has a single error source.
- The checksum covers the length byte and the payload only, not the header.

## Timing
- All decisions are taken on the `in_valid` cycle. The state and register updates are visible the next cycle.
- frame_ok pulses in the cycle after the matching checksum strobe.
- For N>0, the first `out_valid` (buf[0]) asserts in the same cycle as frame_ok.
- frame_err pulses in the cycle after the offending strobe, and the state is HUNT0 in that same cycle.
- Output handshake:
  - `out_byte` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
  - After a transfer, the next byte is presented in the following cycle, giving a maximum throughput of 1 byte/cycle with out_ready held high.
  - `out_valid` deasserts in the cycle after the last transfer.
- Minimum drain latency from the checksum strobe to out_last accepted is N cycles.

## Configuration
- `FRAME_TIMEOUT_EN` defined:
  - A gap counter runs in LEN, PAYLOAD and CSUM. It clears on each `in_valid` and increments otherwise.
  - When it reaches TIMEOUT_CYC: frame_err with err 11, → HUNT0.
  - Timeout takes effect only if no `in_valid` occurs in that cycle; a byte arriving in that cycle wins.
  - The counter is idle in HUNT0, HUNT1 and DRAIN.
- `FRAME_TIMEOUT_EN` undefined: no counter is instantiated; the parser waits indefinitely and err_code 11 never occurs.

## Test plan
- Good frame: bytes 55 AA 03 11 22 33 69 with out_ready=1 → frame_ok once; out stream 11,22,33 with out_last only on 33; no frame_err.
- Bad checksum: 55 AA 03 11 22 33 68 → frame_err with err_code 01; no out_valid; the parser then accepts the good frame from the first scenario.
- Resync and oversize: 55 55 AA 40 → frame_err with err_code 10 after the 0x40 strobe (MAX_LEN=32); then 55 AA 00 00 → frame_ok with no out_valid.
- Backpressure: good frame with out_ready toggled 0/1 every other cycle → out_byte stable while stalled, 3 transfers in order, one extra byte injected during DRAIN gives frame_err with err_code 00.
- Reset mid-payload: reset asserted after 55 AA 03 11 → all outputs 0, no pulses; the subsequent good frame parses correctly.
- FRAME_TIMEOUT_EN with TIMEOUT_CYC=64: 55 AA 03 11 then silence → frame_err with err_code 11 exactly 64 cycles after the 0x11 strobe; without the macro, no pulse over 1000 cycles.
